// File: rtl/riscv_dcache_pkg.sv
// rtl/riscv_dcache_pkg.sv - shared FSM encodings, memory-port codes and address-field helpers for riscv_dcache
package riscv_dcache_pkg;

    typedef enum logic [2:0] {
        DC_IDLE        = 3'd0,
        DC_REFILL_REQ  = 3'd1,
        DC_REFILL_WAIT = 3'd2,
        DC_READ_RESP   = 3'd3,
        DC_WRITE_REQ   = 3'd4,
        DC_WRITE_WAIT  = 3'd5
    } dc_state_e;

    localparam logic MEM_WE_READ  = 1'b0;
    localparam logic MEM_WE_WRITE = 1'b1;

    localparam int ADDR_W = 32;

    // Tag width left over after the byte offset, word index and line index.
    function automatic int tag_width(input int num_lines, input int line_words);
        return ADDR_W - 2 - $clog2(num_lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/riscv_dcache_array.sv
// rtl/riscv_dcache_array.sv - flop-based tag/valid/data storage with combinational read, byte write and line-fill ports
module riscv_dcache_array #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_LINES  = 16,
    parameter  int LINE_WORDS = 4,
    parameter  int TAG_W      = 26,
    localparam int LINE_W     = $clog2(NUM_LINES),
    localparam int WORD_W     = $clog2(LINE_WORDS),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic [LINE_W-1:0]     line_i,
    input  logic [WORD_W-1:0]     word_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [STRB_W-1:0]     wr_strb_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  fill_en_i,
    input  logic [WORD_W-1:0]     fill_word_i,
    input  logic [DATA_WIDTH-1:0] fill_data_i,
    input  logic                  inval_i,
    input  logic                  commit_i,
    input  logic [TAG_W-1:0]      commit_tag_i
);

    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES*LINE_WORDS];

    assign rd_valid_o = valid_q[line_i];
    assign rd_tag_o   = tag_q[line_i];
    assign rd_data_o  = data_q[{line_i, word_i}];

    // Only the valid bits need reset; tag and data are qualified by them.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            valid_q <= '0;
        end else if (inval_i) begin
            valid_q[line_i] <= 1'b0;
        end else if (commit_i) begin
            valid_q[line_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (commit_i) begin
            tag_q[line_i] <= commit_tag_i;
        end
        if (fill_en_i) begin
            data_q[{line_i, fill_word_i}] <= fill_data_i;
        end else if (wr_en_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_i[b]) begin
                    data_q[{line_i, word_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/riscv_dcache.sv
// rtl/riscv_dcache.sv - direct-mapped write-through no-allocate data cache; RISCV_DCACHE_STATS_EN adds hit/miss counters
module riscv_dcache
    import riscv_dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    srst_n,
    input  logic                    read_req,
    input  logic [DATA_WIDTH/8-1:0] write_req,
    input  logic [31:0]             addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic                    dcache_busy,
    output logic                    read_ack,
    output logic                    write_ack,
    output logic                    rdata_val,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef RISCV_DCACHE_STATS_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`endif
);

    localparam int LINE_W = $clog2(NUM_LINES);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = tag_width(NUM_LINES, LINE_WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS);

    dc_state_e              state_q, state_d;
    logic [29:0]            waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]       recv_cnt_q, recv_cnt_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   rdata_val_q, rdata_val_d;

    logic [WORD_W-1:0]      req_word, lat_word, word_sel;
    logic [LINE_W-1:0]      req_line, lat_line, line_sel;
    logic [TAG_W-1:0]       req_tag, lat_tag;
    logic                   rd_valid;
    logic [TAG_W-1:0]       rd_tag;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   hit;
    logic                   wr_en, fill_en, inval, commit;
    logic                   stat_hit, stat_miss;
    logic [1:0]             byte_offset_unused;

    assign req_word = addr[2 +: WORD_W];
    assign req_line = addr[2+WORD_W +: LINE_W];
    assign req_tag  = addr[31 -: TAG_W];
    assign lat_word = waddr_q[0 +: WORD_W];
    assign lat_line = waddr_q[WORD_W +: LINE_W];
    assign lat_tag  = waddr_q[29 -: TAG_W];
    assign byte_offset_unused = addr[1:0];

    // In IDLE the array looks at the live request; otherwise at the latched one.
    assign line_sel = (state_q == DC_IDLE) ? req_line : lat_line;
    assign word_sel = (state_q == DC_IDLE) ? req_word : lat_word;
    assign hit      = rd_valid && (rd_tag == req_tag);

    riscv_dcache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk          (clk),
        .srst_n       (srst_n),
        .line_i       (line_sel),
        .word_i       (word_sel),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_en_i      (wr_en),
        .wr_strb_i    (write_req),
        .wr_data_i    (write_data),
        .fill_en_i    (fill_en),
        .fill_word_i  (recv_cnt_q[WORD_W-1:0]),
        .fill_data_i  (mem_rdata),
        .inval_i      (inval),
        .commit_i     (commit),
        .commit_tag_i (lat_tag)
    );

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q     <= DC_IDLE;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            rdata_q     <= '0;
            rdata_val_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            rdata_q     <= rdata_d;
            rdata_val_q <= rdata_val_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        rdata_d     = rdata_q;
        rdata_val_d = 1'b0;
        read_ack    = 1'b0;
        write_ack   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = MEM_WE_READ;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        wr_en       = 1'b0;
        fill_en     = 1'b0;
        inval       = 1'b0;
        commit      = 1'b0;
        stat_hit    = 1'b0;
        stat_miss   = 1'b0;

        case (state_q)
            DC_IDLE: begin
                if (read_req) begin
                    if (hit) begin
                        read_ack    = 1'b1;
                        rdata_d     = rd_data;
                        rdata_val_d = 1'b1;
                        stat_hit    = 1'b1;
                    end else begin
                        // Drop the victim now so a reset mid-fill leaves no stale line.
                        waddr_d     = addr[31:2];
                        issue_cnt_d = '0;
                        recv_cnt_d  = '0;
                        inval       = 1'b1;
                        stat_miss   = 1'b1;
                        state_d     = DC_REFILL_REQ;
                    end
                end else if (write_req != '0) begin
                    waddr_d = addr[31:2];
                    wdata_d = write_data;
                    wstrb_d = write_req;
                    wr_en   = hit;
                    state_d = DC_WRITE_REQ;
                end
            end
            DC_REFILL_REQ, DC_REFILL_WAIT: begin
                if (state_q == DC_REFILL_REQ) begin
                    mem_req  = 1'b1;
                    mem_addr = {waddr_q[29:WORD_W], issue_cnt_q[WORD_W-1:0], 2'b00};
                    if (mem_ready) begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                        if (issue_cnt_d == LAST_CNT) begin
                            state_d = DC_REFILL_WAIT;
                        end
                    end
                end
                if (mem_rvalid) begin
                    fill_en    = 1'b1;
                    recv_cnt_d = recv_cnt_q + 1'b1;
                    if (recv_cnt_d == LAST_CNT) begin
                        commit  = 1'b1;
                        state_d = DC_READ_RESP;
                    end
                end
            end
            DC_READ_RESP: begin
                read_ack    = 1'b1;
                rdata_d     = rd_data;
                rdata_val_d = 1'b1;
                state_d     = DC_IDLE;
            end
            DC_WRITE_REQ: begin
                mem_req   = 1'b1;
                mem_we    = MEM_WE_WRITE;
                mem_addr  = {waddr_q, 2'b00};
                mem_wdata = wdata_q;
                mem_wstrb = wstrb_q;
                if (mem_ready) begin
                    state_d = DC_WRITE_WAIT;
                end
            end
            DC_WRITE_WAIT: begin
                write_ack = 1'b1;
                state_d   = DC_IDLE;
            end
            default: state_d = DC_IDLE;
        endcase
    end

    assign dcache_busy = (state_q != DC_IDLE);
    assign rdata       = rdata_q;
    assign rdata_val   = rdata_val_q;

`ifdef RISCV_DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (stat_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (stat_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = stat_hit ^ stat_miss;
`endif

endmodule

// File: tb/tb_riscv_dcache.sv
// tb/tb_riscv_dcache.sv - directed vector bench for riscv_dcache with an in-order word memory model
module tb_riscv_dcache;

    logic        clk = 1'b0;
    logic        srst_n;
    logic        read_req;
    logic [3:0]  write_req;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        dcache_busy, read_ack, write_ack, rdata_val;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    riscv_dcache dut (
        .clk         (clk),
        .srst_n      (srst_n),
        .read_req    (read_req),
        .write_req   (write_req),
        .addr        (addr),
        .write_data  (write_data),
        .dcache_busy (dcache_busy),
        .read_ack    (read_ack),
        .write_ack   (write_ack),
        .rdata_val   (rdata_val),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    // Memory model: unwritten words read as {16'hC0DE, addr[15:0]}.
    logic [31:0] mem_words [logic [31:0]];
    logic [31:0] rq [$];
    int          rd_acc = 0, wr_acc = 0, rv_sent = 0, stall_used = 0;
    int          stall_budget = 0;
    bit          inject_rv = 1'b0;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!srst_n) begin
            rq.delete();
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else begin
            if (rq.size() > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_rd(rq.pop_front());
                rv_sent++;
            end else if (inject_rv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0BAD0;
            end else begin
                mem_rvalid = 1'b0;
            end
            if (mem_req && stall_used < stall_budget) begin
                stall_used++;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                logic [31:0] cur;
                mem_ready = 1'b1;
                if (mem_we) begin
                    cur = mem_rd(mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_words[mem_addr] = cur;
                    last_waddr = mem_addr;
                    last_wdata = mem_wdata;
                    last_wstrb = mem_wstrb;
                    wr_acc++;
                end else begin
                    rq.push_back(mem_addr);
                    rd_acc++;
                end
            end else begin
                mem_ready = 1'b0;
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d,
                           output bit got, output bit val, output int cyc);
        @(negedge clk);
        addr = a;
        read_req = 1'b1;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if (read_ack) got = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            if (!got) @(negedge clk);
        end
        read_req = 1'b0;
        val = rdata_val;
        d = rdata;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] dat,
                            output bit got, output int cyc);
        @(negedge clk);
        addr = a;
        write_req = s;
        write_data = dat;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if (write_ack) got = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            if (!got) @(negedge clk);
        end
        write_req = '0;
    endtask

    typedef struct {
        bit          st;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
        int          exp_rd;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [31:0] d;
        bit          got, val;
        int          cyc, rd0, wr0, rv0;
        logic [31:0] outs_cat;

        mem_words[32'h100] = 32'h000000A0;
        mem_words[32'h104] = 32'h000000A1;
        mem_words[32'h108] = 32'h000000A2;
        mem_words[32'h10C] = 32'h000000A3;

        vecs[0]  = '{1'b0, 32'h100,  4'h0, 32'h0,        32'h000000A0, 4};
        vecs[1]  = '{1'b0, 32'h108,  4'h0, 32'h0,        32'h000000A2, 0};
        vecs[2]  = '{1'b0, 32'h104,  4'h0, 32'h0,        32'h000000A1, 0};
        vecs[3]  = '{1'b1, 32'h102,  4'h4, 32'h55555555, 32'h0,        0};
        vecs[4]  = '{1'b0, 32'h100,  4'h0, 32'h0,        32'h005500A0, 0};
        vecs[5]  = '{1'b1, 32'h2000, 4'hF, 32'hDEADBEEF, 32'h0,        0};
        vecs[6]  = '{1'b0, 32'h2000, 4'h0, 32'h0,        32'hDEADBEEF, 4};
        vecs[7]  = '{1'b0, 32'h200,  4'h0, 32'h0,        32'hC0DE0200, 4};
        vecs[8]  = '{1'b0, 32'h100,  4'h0, 32'h0,        32'h005500A0, 4};
        vecs[9]  = '{1'b0, 32'h10C,  4'h0, 32'h0,        32'h000000A3, 0};
        vecs[10] = '{1'b1, 32'h10D,  4'h2, 32'h77777777, 32'h0,        0};
        vecs[11] = '{1'b0, 32'h10C,  4'h0, 32'h0,        32'h000077A3, 0};
        vecs[12] = '{1'b1, 32'h444,  4'h1, 32'hABABABAB, 32'h0,        0};
        vecs[13] = '{1'b0, 32'h444,  4'h0, 32'h0,        32'hC0DE04AB, 4};
        vecs[14] = '{1'b0, 32'h0F0,  4'h0, 32'h0,        32'hC0DE00F0, 4};
        vecs[15] = '{1'b0, 32'h0FC,  4'h0, 32'h0,        32'hC0DE00FC, 0};
        vecs[16] = '{1'b0, 32'h440,  4'h0, 32'h0,        32'hC0DE0440, 0};

        srst_n = 1'b0;
        read_req = 1'b0;
        write_req = '0;
        addr = '0;
        write_data = '0;
        repeat (3) @(negedge clk);
        #1;
        outs_cat = {dcache_busy, read_ack, write_ack, rdata_val, mem_req, mem_we, 26'd0}
                   | rdata | mem_addr | mem_wdata | {28'd0, mem_wstrb};
        chk("reset_outputs", outs_cat, 32'h0);
        srst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            rd0 = rd_acc;
            wr0 = wr_acc;
            if (vecs[i].st) begin
                do_store(vecs[i].a, vecs[i].s, vecs[i].d, got, cyc);
                chk($sformatf("v%0d_write_ack", i), {31'd0, got}, 32'd1);
                chk($sformatf("v%0d_min_cycles", i), {31'd0, cyc >= 3}, 32'd1);
                chk($sformatf("v%0d_mem_writes", i), wr_acc - wr0, 32'd1);
                chk($sformatf("v%0d_mem_reads", i), rd_acc - rd0, 32'd0);
                chk($sformatf("v%0d_waddr", i), last_waddr, vecs[i].a & 32'hFFFF_FFFC);
                chk($sformatf("v%0d_wstrb", i), {28'd0, last_wstrb}, {28'd0, vecs[i].s});
                chk($sformatf("v%0d_wdata", i), last_wdata, vecs[i].d);
            end else begin
                do_load(vecs[i].a, d, got, val, cyc);
                chk($sformatf("v%0d_read_ack", i), {31'd0, got}, 32'd1);
                chk($sformatf("v%0d_rdata_val", i), {31'd0, val}, 32'd1);
                chk($sformatf("v%0d_rdata", i), d, vecs[i].exp);
                chk($sformatf("v%0d_mem_reads", i), rd_acc - rd0, vecs[i].exp_rd);
                if (vecs[i].exp_rd == 0)
                    chk($sformatf("v%0d_hit_latency", i), cyc, 32'd1);
            end
        end

        // Backpressure: five refused issue cycles at the start of a refill.
        stall_budget = stall_used + 5;
        rd0 = rd_acc;
        fork
            do_load(32'h3008, d, got, val, cyc);
            begin
                bit seen = 1'b0;
                bit stable = 1'b1;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    #2;
                    if (mem_req) seen = 1'b1;
                end
                chk("bp_mem_req_seen", {31'd0, seen}, 32'd1);
                for (int k = 0; k < 5; k++) begin
                    if (mem_addr !== 32'h3000 || !dcache_busy || mem_ready || !mem_req)
                        stable = 1'b0;
                    @(negedge clk);
                    #2;
                end
                chk("bp_addr_busy_held", {31'd0, stable}, 32'd1);
            end
        join
        chk("bp_read_ack", {31'd0, got}, 32'd1);
        chk("bp_rdata", d, 32'hC0DE3008);
        chk("bp_mem_reads", rd_acc - rd0, 32'd4);

        // Reset after two refill beats, then a stray beat while idle.
        rv0 = rv_sent;
        @(negedge clk);
        addr = 32'h100;
        read_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            #2;
            if (rv_sent - rv0 >= 2) got = 1'b1;
        end
        chk("rst_two_beats_seen", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        srst_n = 1'b0;
        read_req = 1'b0;
        #1;
        outs_cat = {dcache_busy, read_ack, write_ack, rdata_val, mem_req, mem_we, 26'd0}
                   | rdata | mem_addr | mem_wdata | {28'd0, mem_wstrb};
        chk("midrefill_reset_outputs", outs_cat, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        srst_n = 1'b1;
        @(negedge clk);
        #3;
        inject_rv = 1'b1;
        @(negedge clk);
        #3;
        inject_rv = 1'b0;
        @(posedge clk);
        #1;
        chk("stray_beat_ignored", {30'd0, dcache_busy, rdata_val}, 32'd0);
        rd0 = rd_acc;
        do_load(32'h100, d, got, val, cyc);
        chk("rst_reload_ack", {31'd0, got}, 32'd1);
        chk("rst_reload_rdata", d, 32'h005500A0);
        chk("rst_reload_reads", rd_acc - rd0, 32'd4);

        // Read and write together: the read is served, the write is not started.
        wr0 = wr_acc;
        @(negedge clk);
        addr = 32'h104;
        read_req = 1'b1;
        write_req = 4'hF;
        write_data = 32'h12345678;
        #1;
        chk("prio_read_ack", {31'd0, read_ack}, 32'd1);
        @(posedge clk);
        #1;
        read_req = 1'b0;
        write_req = '0;
        chk("prio_not_busy", {31'd0, dcache_busy}, 32'd0);
        chk("prio_rdata", rdata, 32'h000000A1);
        repeat (3) @(negedge clk);
        chk("prio_no_mem_write", wr_acc - wr0, 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
